// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and resolve-side update bus for branch_predictor.
// Purely combinational prediction; one update per cycle; no backpressure.
interface branch_predictor_if;
  logic [63:0] PC_F;
  logic        PredHit;
  logic        PredTaken;
  logic [63:0] PredTarget;
  logic        UpdEn;
  logic [63:0] UpdPC;
  logic        UpdTaken;
  logic [63:0] UpdTarget;
  logic [31:0] MispredCnt;

  modport master (
    output PC_F, UpdEn, UpdPC, UpdTaken, UpdTarget,
    input  PredHit, PredTaken, PredTarget, MispredCnt
  );

  modport slave (
    input  PC_F, UpdEn, UpdPC, UpdTaken, UpdTarget,
    output PredHit, PredTaken, PredTarget, MispredCnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 2-bit counters; define BP_GSHARE_EN to XOR global history into the index.
// Prediction is combinational (0 cycles), updates land at the next edge; always ready, no backpressure.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 12,
  parameter int GHR_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  logic [ENTRIES-1:0]       valid_q;
  logic [ENTRIES-1:0][1:0]  ctr_q;
  tag_t                     tag_q    [ENTRIES];
  logic [63:0]              target_q [ENTRIES];
  logic [31:0]              mispred_cnt;

  idx_t pred_idx;
  idx_t upd_idx;
  tag_t pred_tag;
  tag_t upd_tag;

  assign pred_tag = bp.PC_F[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_tag  = bp.UpdPC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS:0]   ghr_sh;

  assign ghr_sh   = {ghr, bp.UpdTaken};
  assign pred_idx = bp.PC_F[IDX_BITS+1:2] ^ idx_t'(ghr);
  assign upd_idx  = bp.UpdPC[IDX_BITS+1:2] ^ idx_t'(ghr);

  // History shifts after this edge's index has already been formed from the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (bp.UpdEn) begin
      ghr <= ghr_sh[GHR_BITS-1:0];
    end
  end
`else
  assign pred_idx = bp.PC_F[IDX_BITS+1:2];
  assign upd_idx  = bp.UpdPC[IDX_BITS+1:2];
`endif

  logic unused_upd_bits;
  assign unused_upd_bits = ^{bp.UpdPC[63:IDX_BITS+TAG_BITS+2], bp.UpdPC[1:0]};

  logic       pred_hit;
  logic       pred_taken;
  logic       upd_hit;
  logic [1:0] upd_ctr;
  logic [1:0] ctr_upd;
  logic       mispredict;

  assign pred_hit   = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken = pred_hit && ctr_q[pred_idx][1];

  assign bp.PredHit    = pred_hit;
  assign bp.PredTaken  = pred_taken;
  assign bp.PredTarget = pred_taken ? target_q[pred_idx] : bp.PC_F + 64'd4;
  assign bp.MispredCnt = mispred_cnt;

  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr    = ctr_q[upd_idx];
  assign mispredict = bp.UpdTaken != (upd_hit && upd_ctr[1]);

  always_comb begin
    ctr_upd = upd_ctr;
    if (bp.UpdTaken) begin
      if (upd_ctr != 2'b11) ctr_upd = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'b00) ctr_upd = upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      ctr_q       <= {ENTRIES{2'b01}};
      mispred_cnt <= '0;
    end else if (bp.UpdEn) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_upd;
      end else if (bp.UpdTaken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'b10;
      end
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // Tags and targets need no reset: a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (!rst && bp.UpdEn && bp.UpdTaken) begin
      target_q[upd_idx] <= bp.UpdTarget;
      if (!upd_hit) tag_q[upd_idx] <= upd_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against a table model.
module tb_branch_predictor;

  localparam int ENTRIES  = 64;
  localparam int TAG_MOD  = 4096;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  branch_predictor_if bp ();

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: one record per slot, counter kept as a plain integer 0..3.
  bit          m_valid  [ENTRIES];
  logic [63:0] m_tag    [ENTRIES];
  logic [63:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_cnt;

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [63:0] m_tagof(input logic [63:0] pc);
    return (pc / (4 * ENTRIES)) % TAG_MOD;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_cnt = 32'd0;
  endtask

  task automatic model_pred(input logic [63:0] pc, output bit hit, output bit tk,
                            output logic [63:0] tgt);
    int i;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_target[i] : pc + 64'd4;
  endtask

  task automatic model_update(input logic [63:0] pc, input bit tk, input logic [63:0] tgt);
    bit          hit;
    bit          ptk;
    logic [63:0] ptgt;
    int          i;
    i = m_idx(pc);
    model_pred(pc, hit, ptk, ptgt);
    if (tk != ptk) m_cnt = m_cnt + 32'd1;
    if (hit) begin
      m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                    : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
      if (tk) m_target[i] = tgt;
    end else if (tk) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = m_tagof(pc);
      m_target[i] = tgt;
      m_ctr[i]    = 2;
    end
  endtask

  task automatic apply_update(input logic [63:0] pc, input bit tk, input logic [63:0] tgt);
    bp.UpdEn     = 1'b1;
    bp.UpdPC     = pc;
    bp.UpdTaken  = tk;
    bp.UpdTarget = tgt;
    model_update(pc, tk, tgt);
    @(posedge clk);
    #1;
    bp.UpdEn = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bp.PC_F      = 64'h1000;
    bp.UpdEn     = 1'b0;
    bp.UpdPC     = '0;
    bp.UpdTaken  = 1'b0;
    bp.UpdTarget = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b0) begin
      n_err++; $display("FAIL reset_hit: got %0b want 0", bp.PredHit);
    end
    n_cmp++;
    if (bp.PredTaken !== 1'b0) begin
      n_err++; $display("FAIL reset_taken: got %0b want 0", bp.PredTaken);
    end
    n_cmp++;
    if (bp.PredTarget !== 64'h1004) begin
      n_err++; $display("FAIL reset_target: got %h want 1004", bp.PredTarget);
    end
    n_cmp++;
    if (bp.MispredCnt !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", bp.MispredCnt);
    end
  endtask

  task automatic test_alloc();
    apply_update(64'h1000, 1'b1, 64'h2000);
    bp.PC_F = 64'h1000;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b1 || bp.PredTaken !== 1'b1) begin
      n_err++; $display("FAIL alloc_hit_taken: got %0b/%0b want 1/1", bp.PredHit, bp.PredTaken);
    end
    n_cmp++;
    if (bp.PredTarget !== 64'h2000) begin
      n_err++; $display("FAIL alloc_target: got %h want 2000", bp.PredTarget);
    end
    n_cmp++;
    if (bp.MispredCnt !== 32'd1) begin
      n_err++; $display("FAIL alloc_cnt: got %0d want 1", bp.MispredCnt);
    end
  endtask

  task automatic test_decrement();
    apply_update(64'h1000, 1'b0, 64'h0);
    apply_update(64'h1000, 1'b0, 64'h0);
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b1 || bp.PredTaken !== 1'b0) begin
      n_err++; $display("FAIL dec_hit_taken: got %0b/%0b want 1/0", bp.PredHit, bp.PredTaken);
    end
    n_cmp++;
    if (bp.PredTarget !== 64'h1004) begin
      n_err++; $display("FAIL dec_target: got %h want 1004", bp.PredTarget);
    end
    n_cmp++;
    if (bp.MispredCnt !== 32'd2) begin
      n_err++; $display("FAIL dec_cnt: got %0d want 2", bp.MispredCnt);
    end
    apply_update(64'h1000, 1'b0, 64'h0);
    @(negedge clk);
    n_cmp++;
    if (bp.MispredCnt !== 32'd2) begin
      n_err++; $display("FAIL sat_low_cnt: got %0d want 2", bp.MispredCnt);
    end
    // A saturated-low counter rises only to 01, so one taken update still predicts not-taken.
    apply_update(64'h1000, 1'b1, 64'h2000);
    @(negedge clk);
    n_cmp++;
    if (bp.PredTaken !== 1'b0 || bp.MispredCnt !== 32'd3) begin
      n_err++; $display("FAIL sat_low_probe: got taken=%0b cnt=%0d want taken=0 cnt=3",
                        bp.PredTaken, bp.MispredCnt);
    end
  endtask

  task automatic test_replace();
    apply_update(64'h1100, 1'b1, 64'h5000);
    bp.PC_F = 64'h1000;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b0 || bp.PredTarget !== 64'h1004) begin
      n_err++; $display("FAIL replace_old: got hit=%0b tgt=%h want hit=0 tgt=1004",
                        bp.PredHit, bp.PredTarget);
    end
    bp.PC_F = 64'h1100;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b1 || bp.PredTaken !== 1'b1 || bp.PredTarget !== 64'h5000) begin
      n_err++; $display("FAIL replace_new: got hit=%0b tk=%0b tgt=%h want 1/1/5000",
                        bp.PredHit, bp.PredTaken, bp.PredTarget);
    end
    n_cmp++;
    if (bp.MispredCnt !== 32'd4) begin
      n_err++; $display("FAIL replace_cnt: got %0d want 4", bp.MispredCnt);
    end
  endtask

  task automatic test_same_cycle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bp.PC_F      = 64'h3000;
    bp.UpdEn     = 1'b1;
    bp.UpdPC     = 64'h3000;
    bp.UpdTaken  = 1'b1;
    bp.UpdTarget = 64'h4000;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b0 || bp.PredTarget !== 64'h3004) begin
      n_err++; $display("FAIL same_cycle_pre: got hit=%0b tgt=%h want hit=0 tgt=3004",
                        bp.PredHit, bp.PredTarget);
    end
    model_update(64'h3000, 1'b1, 64'h4000);
    @(posedge clk);
    #1;
    bp.UpdEn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b1 || bp.PredTarget !== 64'h4000) begin
      n_err++; $display("FAIL same_cycle_post: got hit=%0b tgt=%h want hit=1 tgt=4000",
                        bp.PredHit, bp.PredTarget);
    end
  endtask

  task automatic test_wrap_and_reset();
    @(posedge clk);
    #1;
    force dut.mispred_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt;
    m_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if (bp.MispredCnt !== m_cnt) begin
      n_err++; $display("FAIL wrap_preload: got %h want %h", bp.MispredCnt, m_cnt);
    end
    apply_update(64'h3000, 1'b0, 64'h0);
    @(negedge clk);
    n_cmp++;
    if (bp.MispredCnt !== 32'd0) begin
      n_err++; $display("FAIL wrap_cnt: got %h want 0", bp.MispredCnt);
    end
    bp.UpdEn     = 1'b1;
    bp.UpdPC     = 64'h7000;
    bp.UpdTaken  = 1'b1;
    bp.UpdTarget = 64'h8000;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bp.UpdEn = 1'b0;
    model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      bp.PC_F = 64'h3000 + 64'(i) * 4;
      #1;
      n_cmp++;
      if (bp.PredHit !== 1'b0) begin
        n_err++; $display("FAIL rst_clear_%0d: got hit=%0b want 0", i, bp.PredHit);
      end
    end
    bp.PC_F = 64'h7000;
    @(negedge clk);
    n_cmp++;
    if (bp.PredHit !== 1'b0 || bp.MispredCnt !== 32'd0) begin
      n_err++; $display("FAIL rst_discard: got hit=%0b cnt=%0d want 0/0",
                        bp.PredHit, bp.MispredCnt);
    end
  endtask

  function automatic logic [63:0] rand_pc();
    return (64'($urandom) << 32) | (64'($urandom_range(0, 3)) << 8) |
           (64'($urandom_range(0, 7)) << 2) | 64'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    bit          e_hit;
    bit          e_tk;
    logic [63:0] e_tgt;
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      bp.PC_F      = rand_pc();
      bp.UpdEn     = ($urandom_range(0, 9) < 7);
      bp.UpdPC     = rand_pc();
      bp.UpdTaken  = 1'($urandom_range(0, 1));
      bp.UpdTarget = {$urandom, $urandom};
      @(negedge clk);
      model_pred(bp.PC_F, e_hit, e_tk, e_tgt);
      n_cmp++;
      if (bp.PredHit !== e_hit || bp.PredTaken !== e_tk) begin
        n_err++; $display("FAIL rand_pred[%0d]: got hit=%0b tk=%0b want hit=%0b tk=%0b",
                          c, bp.PredHit, bp.PredTaken, e_hit, e_tk);
      end
      n_cmp++;
      if (bp.PredTarget !== e_tgt) begin
        n_err++; $display("FAIL rand_target[%0d]: got %h want %h", c, bp.PredTarget, e_tgt);
      end
      n_cmp++;
      if (bp.MispredCnt !== m_cnt) begin
        n_err++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, bp.MispredCnt, m_cnt);
      end
      if (bp.UpdEn) model_update(bp.UpdPC, bp.UpdTaken, bp.UpdTarget);
      @(posedge clk);
      #1;
    end
    bp.UpdEn = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_alloc();
    test_decrement();
    test_replace();
    test_same_cycle();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter IDX_BITS, default 6, giving log2 of the number of table entries (64).
REQ-002 The module SHALL have parameter TAG_BITS, default 12, giving the width of the stored tag.
REQ-003 The module SHALL have parameter GHR_BITS, default 6, giving the global history width; legal range 1..IDX_BITS; used only when BP_GSHARE_EN is defined.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port PC_F, input, 64 bits: fetch PC to predict.
REQ-007 The module SHALL have port PredHit, output, 1 bit: a valid entry with matching tag exists for PC_F.
REQ-008 The module SHALL have port PredTaken, output, 1 bit: predicted taken.
REQ-009 The module SHALL have port PredTarget, output, 64 bits: predicted next PC.
REQ-010 The module SHALL have port UpdEn, input, 1 bit: a resolved branch is presented this cycle.
REQ-011 The module SHALL have port UpdPC, input, 64 bits: PC of the resolved branch.
REQ-012 The module SHALL have port UpdTaken, input, 1 bit: resolved outcome (the branch comparator's BrE).
REQ-013 The module SHALL have port UpdTarget, input, 64 bits: resolved taken target.
REQ-014 The module SHALL have port MispredCnt, output, 32 bits: count of mispredicted updates.

Function
REQ-015 Each entry SHALL hold: valid bit, TAG_BITS tag, 64-bit target, 2-bit saturating counter.
REQ-016 Index SHALL be PC[IDX_BITS+1:2]; tag SHALL be PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]; identical for PC_F and UpdPC.
REQ-017 The prediction path SHALL be combinational from PC_F and current table state, with zero-cycle latency.
REQ-018 Prediction outputs SHALL be: PredHit = valid & tag match; PredTaken = PredHit & counter[1]; PredTarget = stored target when PredTaken, else PC_F+4 (modulo 2^64).
REQ-019 On an UpdEn hit, the counter SHALL increment on UpdTaken=1 and decrement on UpdTaken=0, saturating at 2'b11 and 2'b00; when UpdTaken=1 the target SHALL also be overwritten with UpdTarget.
REQ-020 On an UpdEn miss with UpdTaken=1, the entry SHALL be allocated (overwriting any occupant): valid=1, new tag, target=UpdTarget, counter=2'b10.
REQ-021 On an UpdEn miss with UpdTaken=0, the table SHALL NOT change.
REQ-022 A misprediction SHALL be defined as UpdTaken != (update-side hit & counter[1]), evaluated before the write.
REQ-023 MispredCnt SHALL increment by 1 per mispredicted update and wrap from 0xFFFFFFFF to 0.
REQ-024 For a same-cycle predict and update to the same index, the prediction SHALL use the pre-update state (no bypass); the new state SHALL be visible the following cycle.
REQ-025 With UpdEn=0 the table and MispredCnt SHALL hold.

Reset
REQ-026 While rst=1, asynchronously: all valid bits SHALL be 0, all counters 2'b01, MispredCnt 0, GHR 0; tags and targets SHALL be don't-care.
REQ-027 Immediately after reset, outputs SHALL be PredHit=0, PredTaken=0, PredTarget=PC_F+4.
REQ-028 Reset asserted in the same cycle as UpdEn SHALL discard the update.

Configuration
REQ-029 When macro BP_GSHARE_EN is defined, a GHR_BITS global history register SHALL be XORed into the low bits of both the predict and update index, and SHALL shift left inserting UpdTaken on each UpdEn at the clock edge, after that edge's index is formed.
REQ-030 Without BP_GSHARE_EN, no GHR SHALL exist and the indexing of REQ-016 SHALL apply.

Verification
REQ-031 The bench SHALL cover: reset, then PC_F=0x1000 -> PredHit=0, PredTaken=0, PredTarget=0x1004.
REQ-032 The bench SHALL cover: an update with UpdPC=0x1000, taken, target 0x2000; next cycle PC_F=0x1000 -> PredHit=1, PredTaken=1, PredTarget=0x2000, MispredCnt=1.
REQ-033 The bench SHALL cover: two not-taken updates to 0x1000 -> counter 10->01->00, PredTaken=0, MispredCnt=2; a third not-taken update -> counter stays 00, MispredCnt=2.
REQ-034 The bench SHALL cover: an update with UpdPC=0x1100 (same index, different tag), taken -> entry replaced, and PC_F=0x1000 gives PredHit=0.
REQ-035 The bench SHALL cover: a same-cycle update and predict to 0x3000 on an empty table -> PredHit=0 that cycle and PredHit=1 the next cycle.
REQ-036 The bench SHALL cover: MispredCnt preloaded to 0xFFFFFFFF via forced state, then one mispredicted update -> MispredCnt=0; rst pulsed mid-update -> all entries invalid.
